// File: rtl/int_wb_queue.sv
// int_wb_queue: integer writeback FIFO that shares the register-file write port with loads, which always win.
// Optional INT_WB_BYPASS_EN: a result arriving at an empty queue with no load skips the FIFO.
module int_wb_queue #(
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = 4,
  parameter int DATA_W     = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [REG_ADDR_W-1:0]    in_rd,
  input  logic                     mem_wb_valid,
  input  logic [REG_ADDR_W-1:0]    mem_wb_rd,
  input  logic [DATA_W-1:0]        mem_wb_data,
  output logic                     rf_we,
  output logic [REG_ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [2**REG_ADDR_W-1:0] pend_mask
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [REG_ADDR_W-1:0] rd_mem_q [DEPTH];
  logic [DATA_W-1:0]     data_mem_q [DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  rf_we_q, rf_we_d, src_int_q, src_int_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  logic                  xfer, pop, bypass, push;
  assign in_ready = count_q != FULL;
  assign xfer     = in_valid && in_ready && !flush;
  assign pop      = !mem_wb_valid && count_q != '0 && !flush;
`ifdef INT_WB_BYPASS_EN
  assign bypass   = xfer && count_q == '0 && !mem_wb_valid;
`else
  assign bypass   = 1'b0;
`endif
  assign push     = xfer && !bypass;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  always_comb begin
    rf_we_d    = mem_wb_valid || pop || bypass;
    src_int_d  = !mem_wb_valid && (pop || bypass);
    rf_waddr_d = mem_wb_valid ? mem_wb_rd : pop ? rd_mem_q[rd_ptr_q] : bypass ? in_rd : rf_waddr_q;
    rf_wdata_d = mem_wb_valid ? mem_wb_data : pop ? data_mem_q[rd_ptr_q] : bypass ? in_result : rf_wdata_q;
    rd_ptr_d   = flush ? '0 : pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d   = flush ? '0 : push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d    = flush ? '0 : (push && !pop) ? count_q + (PW+1)'(1) :
                 (pop && !push) ? count_q - (PW+1)'(1) : count_q;
  end
  // Only entries between the read pointer and count are live; the source flag marks integer writes in flight.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((PW+1)'(i) < count_q) pend_mask[rd_mem_q[rd_ptr_q + PW'(i)]] = 1'b1;
    if (rf_we_q && src_int_q) pend_mask[rf_waddr_q] = 1'b1;
  end
  always_ff @(posedge clk)
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= in_rd;
      data_mem_q[wr_ptr_q] <= in_result;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      src_int_q  <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      src_int_q  <= src_int_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
endmodule

// File: tb/tb_int_wb_queue.sv
// tb_int_wb_queue: directed and random stimulus against a queue-based writeback reference model.
module tb_int_wb_queue;
  localparam int DEPTH = 2;
  localparam int AW    = 4;
  localparam int DW    = 18;
  logic            clk = 0, rst_n = 0, flush = 0, in_valid = 0, mem_wb_valid = 0;
  logic            in_ready, rf_we;
  logic [DW-1:0]   in_result = 0, mem_wb_data = 0, rf_wdata;
  logic [AW-1:0]   in_rd = 0, mem_wb_rd = 0, rf_waddr;
  logic [2**AW-1:0] pend_mask;
  int n_pass = 0, n_chk = 0;
  typedef struct {logic [AW-1:0] rd; logic [DW-1:0] d;} ent_t;
  ent_t q[$];
  logic m_we = 0, m_src = 0;
  logic [AW-1:0] m_addr = 0;
  logic [DW-1:0] m_data = 0;

  int_wb_queue #(.DEPTH(DEPTH), .REG_ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rd(in_rd), .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd),
    .mem_wb_data(mem_wb_data), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [2**AW-1:0] exp_pend();
    logic [2**AW-1:0] m;
    m = '0;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    if (m_we && m_src) m[m_addr] = 1'b1;
    return m;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rf_we"}, 32'(rf_we), 32'(m_we));
    check({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(m_addr));
    check({tag, ".rf_wdata"}, 32'(rf_wdata), 32'(m_data));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
    check({tag, ".pend_mask"}, 32'(pend_mask), 32'(exp_pend()));
  endtask

  task automatic model_reset();
    q.delete();
    m_we = 0; m_src = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic step(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] res,
                      input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                      input logic fl);
    bit acc;
    in_valid = v; in_rd = rd; in_result = res;
    mem_wb_valid = mv; mem_wb_rd = mrd; mem_wb_data = md; flush = fl;
    acc = v && q.size() < DEPTH;
    if (mv) begin
      m_we = 1; m_src = 0; m_addr = mrd; m_data = md;
    end else if (!fl && q.size() > 0) begin
      m_we = 1; m_src = 1; m_addr = q[0].rd; m_data = q[0].d;
      void'(q.pop_front());
    end
`ifdef INT_WB_BYPASS_EN
    else if (!fl && acc) begin
      m_we = 1; m_src = 1; m_addr = rd; m_data = res; acc = 0;
    end
`endif
    else begin
      m_we = 0; m_src = 0;
    end
    if (fl) q.delete();
    else if (acc) q.push_back('{rd, res});
    @(posedge clk);
    #1;
    check_all("step");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 0; in_valid = 0; mem_wb_valid = 0; flush = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #1;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    step(1, 3, 18'h12345, 0, 0, 0, 0);
    idle(4);
    step(1, 1, 18'h00101, 1, 5, 18'h3FFFF, 0);
    step(1, 2, 18'h00202, 1, 5, 18'h3FFFF, 0);
    step(1, 4, 18'h00404, 1, 5, 18'h3FFFF, 0);
    step(1, 4, 18'h00404, 1, 5, 18'h3FFFF, 0);
    step(1, 4, 18'h00404, 0, 0, 0, 0);
    step(1, 4, 18'h00404, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 6; i++) step(1, 4'(i + 8), 18'(i * 18'h1111), 0, 0, 0, 0);
    idle(3);
    step(1, 9, 18'h0AAAA, 1, 6, 18'h15555, 0);
    step(1, 10, 18'h0BBBB, 1, 6, 18'h15555, 0);
    step(1, 11, 18'h0CCCC, 0, 0, 0, 1);
    idle(3);
    step(1, 12, 18'h01212, 1, 2, 18'h00022, 0);
    step(1, 13, 18'h01313, 1, 2, 18'h00022, 0);
    async_reset();
    idle(3);
    step(1, 7, 18'h07777, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7, 18'h3ABCD, 0);
    idle(4);
    for (int c = 0; c < 400; c++) begin
      step($urandom % 4 != 0, 4'($urandom), 18'($urandom),
           ($urandom % 100) < (c < 200 ? 30 : 75), 4'($urandom), 18'($urandom),
           $urandom % 20 == 0);
      if ($urandom % 150 == 0) async_reset();
    end
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
